bpsk_demod: RTL and testbench
=============================

Name: bpsk_demod

Overview:
Coherent BPSK demodulator. It is the receive-side counterpart of the team's BPSK modulator, which sends +sin for bit 1 and −sin for bit 0 on 12-bit two's-complement samples. The block multiplies each received sample by a locally supplied reference sine and integrates over one symbol period. At each symbol boundary it emits a hard bit decision plus the raw correlation value for the Nios-side BER and diagnostic logic.

Parameters:
SAMPLES_PER_SYM, 16, accepted samples per symbol (≥2).
ACC_W, 32, accumulator/correlation width in bits; must be ≥ 24 + clog2(SAMPLES_PER_SYM).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sample_valid  input  1  rx_in/ref_in valid this cycle
rx_in  input  12  received sample, two's complement carried on an unsigned port
ref_in  input  12  reference sine sample, phase-aligned to the carrier, same encoding
sym_start  input  1  symbol alignment pulse; restarts integration
bit_out  output  1  decided bit (1 = in phase with reference)
bit_valid  output  1  one-cycle pulse qualifying bit_out/corr_out
corr_out  output  ACC_W  signed symbol correlation, two's complement on unsigned port
sample_cnt  output  clog2(SAMPLES_PER_SYM)  samples accepted in current symbol

Behaviour:
- Reset (async, active-high): all outputs 0; accumulator 0; counter 0; pipeline valid flags 0. Deassertion is synchronous to clk. Reset mid-symbol discards the partial symbol.
- Arithmetic:
  - rx_in and ref_in are reinterpreted as signed 12-bit.
  - Product is signed 24-bit; −2048 × −2048 = +4194304 must be exact.
  - Product is sign-extended to ACC_W before accumulation.
  - No saturation; the ACC_W rule guarantees no overflow.
- Pipeline, two stages:
  - S1 (cycle after acceptance): register product, valid, and a last flag. last is set when the sample is number SAMPLES_PER_SYM−1 of the symbol.
  - S2: acc <= acc + product. If last, instead:
    - corr_out <= acc + product
    - bit_out <= (acc + product >= 0)
    - bit_valid <= 1
    - acc <= 0
- Latency: last sample accepted in cycle N → bit_valid high during cycle N+2 only.
- Otherwise bit_valid = 0. bit_out and corr_out hold their last values.
- Decision tie: correlation exactly 0 decides bit 1.
- Counter:
  - Increments on each accepted sample.
  - Wraps SAMPLES_PER_SYM−1 → 0 on the last sample.
  - Gaps in sample_valid simply pause integration; there is no timeout.
- sym_start:
  - Clears the counter and acc.
  - Invalidates the product currently in S1.
  - Any symbol whose bit_valid has not yet been asserted is discarded; no bit is emitted for it.
  - If sample_valid is high in the same cycle, that sample is accepted as sample 0 of the new symbol, so sample_cnt = 1 next cycle.
  - sym_start in the same cycle that S2 processes a last product: the decision still completes (bit_valid asserts next cycle), then acc is 0.
- Continuous streaming: back-to-back symbols at one sample/cycle produce bit_valid every SAMPLES_PER_SYM cycles with no bubble.

Test Plan:
1. SAMPLES_PER_SYM=4, rx=ref=100 for 4 consecutive samples → bit_valid 2 cycles after the 4th sample, corr_out=40000, bit_out=1.
2. rx=12'hF9C (−100), ref=100, 4 samples → corr_out=−40000 (32'hFFFF63C0), bit_out=0; then rx=0 for 4 samples → corr_out=0, bit_out=1 (tie rule).
3. Default params, rx=ref=12'h800 for 16 samples → corr_out=67108864, bit_out=1, no overflow.
4. SPS=4, 2 samples of +100·+100, then sym_start with sample_valid and +100·−100 for 4 samples → exactly one bit_valid, corr_out=−40000, bit_out=0.
5. SPS=4, sample_valid toggling every other cycle, 4 samples of 50·50 → single bit_valid, corr_out=10000; sample_cnt steps 1,2,3,0.
6. Loopback with the modulator driven by a known LFSR pattern, ref = modulator sin_in delayed 1 cycle, sym_start aligned → decoded bits match the LFSR sequence. Then assert reset mid-symbol → outputs 0 immediately, and the next full symbol decodes correctly.

Source files
------------

// File: rtl/bpsk_demod_if.sv
// bpsk_demod_if
// Bundles the sample stream going into the BPSK demodulator and the decision
// stream coming out of it.
//
// Handshake: sample_valid qualifies rx_in/ref_in for one cycle. There is no
// back-pressure; the demodulator accepts every valid sample. sym_start is a
// one-cycle alignment strobe. bit_valid is a one-cycle pulse qualifying
// bit_out/corr_out. Both of those hold their values between pulses.
// sample_cnt is a free-running view of the in-symbol sample counter.
//
// Signals:
//   sample_valid  master->slave  rx_in/ref_in valid this cycle
//   rx_in [11:0]  master->slave  received sample, two's complement
//   ref_in[11:0]  master->slave  reference sine sample, two's complement
//   sym_start     master->slave  restart integration at a symbol boundary
//   bit_out       slave->master  decided bit (1 = in phase with reference)
//   bit_valid     slave->master  qualifies bit_out/corr_out
//   corr_out      slave->master  signed symbol correlation
//   sample_cnt    slave->master  samples accepted in current symbol
interface bpsk_demod_if #(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int ACC_W           = 32
);
    localparam int CNT_W = $clog2(SAMPLES_PER_SYM);

    logic             sample_valid;
    logic [11:0]      rx_in;
    logic [11:0]      ref_in;
    logic             sym_start;
    logic             bit_out;
    logic             bit_valid;
    logic [ACC_W-1:0] corr_out;
    logic [CNT_W-1:0] sample_cnt;

    modport master (
        output sample_valid, rx_in, ref_in, sym_start,
        input  bit_out, bit_valid, corr_out, sample_cnt
    );

    modport slave (
        input  sample_valid, rx_in, ref_in, sym_start,
        output bit_out, bit_valid, corr_out, sample_cnt
    );
endinterface

// File: rtl/bpsk_demod.sv
// bpsk_demod
// Coherent BPSK demodulator. Each accepted received sample is multiplied by
// the reference sine sample, the products are integrated over one symbol and
// the sign of the sum gives the hard decision (a zero sum decides 1).
//
// Pipeline: S1 registers the product and a "last sample of symbol" flag,
// S2 accumulates. The last sample accepted in cycle N yields bit_valid in
// cycle N+2.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    bpsk_demod_if slave modport (samples in, decisions out)
module bpsk_demod #(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int ACC_W           = 32
) (
    input  logic         clk,
    input  logic         reset,
    bpsk_demod_if.slave  bus
);
    localparam int CNT_W = $clog2(SAMPLES_PER_SYM);

    logic [CNT_W-1:0]  cnt;
    logic              in_last;
    logic signed [23:0] rx_ext;
    logic signed [23:0] ref_ext;
    logic signed [23:0] prod;

    logic              s1_valid;
    logic              s1_last;
    logic signed [23:0] s1_prod;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic              emit;
    logic              keep;

    logic              bit_q;
    logic              bit_valid_q;
    logic [ACC_W-1:0]  corr_q;

    // Widen both operands to 24 bits first so the product of two 12-bit
    // values is exact, including -2048 * -2048.
    assign rx_ext  = {{12{bus.rx_in[11]}},  bus.rx_in};
    assign ref_ext = {{12{bus.ref_in[11]}}, bus.ref_in};
    assign prod    = rx_ext * ref_ext;

    // A sample arriving with sym_start is sample 0, never the last one.
    assign in_last = (cnt == CNT_W'(SAMPLES_PER_SYM - 1)) && !bus.sym_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (bus.sym_start) begin
            cnt <= bus.sample_valid ? CNT_W'(1) : '0;
        end else if (bus.sample_valid) begin
            cnt <= in_last ? '0 : cnt + CNT_W'(1);
        end
    end

    // S1: product register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= bus.sample_valid;
            s1_last  <= bus.sample_valid && in_last;
            if (bus.sample_valid) begin
                s1_prod <= prod;
            end
        end
    end

    // S2: integrate. A last product finishes its symbol even when sym_start
    // arrives in the same cycle; any other product in S1 at sym_start belongs
    // to the symbol being abandoned and is dropped.
    assign prod_ext = {{(ACC_W-24){s1_prod[23]}}, s1_prod};
    assign sum      = acc + prod_ext;
    assign emit     = s1_valid && s1_last;
    assign keep     = s1_valid && !s1_last && !bus.sym_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            corr_q      <= '0;
        end else begin
            bit_valid_q <= emit;
            if (emit) begin
                corr_q <= sum;
                bit_q  <= ~sum[ACC_W-1];
            end
            if (emit || bus.sym_start) begin
                acc <= '0;
            end else if (keep) begin
                acc <= sum;
            end
        end
    end

    assign bus.bit_out    = bit_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.corr_out   = corr_q;
    assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_bpsk_demod.sv
// tb_bpsk_demod
// Drives two demodulators (4 and 16 samples per symbol) from the same sample
// stream. A symbol-level reference model sums products per symbol and pushes
// {bit, corr} into a queue per DUT; a negedge monitor pops and compares on
// every bit_valid and also checks sample_cnt and reset values.
module tb_bpsk_demod;
    logic clk;
    logic rst;

    bpsk_demod_if #(.SAMPLES_PER_SYM(4),  .ACC_W(32)) bus4 ();
    bpsk_demod_if #(.SAMPLES_PER_SYM(16), .ACC_W(32)) bus16 ();

    assign bus16.sample_valid = bus4.sample_valid;
    assign bus16.rx_in        = bus4.rx_in;
    assign bus16.ref_in       = bus4.ref_in;
    assign bus16.sym_start    = bus4.sym_start;

    bpsk_demod #(.SAMPLES_PER_SYM(4),  .ACC_W(32)) dut4  (.clk(clk), .reset(rst), .bus(bus4));
    bpsk_demod #(.SAMPLES_PER_SYM(16), .ACC_W(32)) dut16 (.clk(clk), .reset(rst), .bus(bus16));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int          sps_tab[2] = '{4, 16};
    longint      part_sum[2];
    int          part_cnt[2];
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    bit          lfsr_q[$];
    bit          lb_mode;
    int          total;
    int          bad;
    bit          final_chk;
    bit          final_done;
    logic [7:0]  lfsr;
    int          ph;
    int          sine_tab[16] = '{0, 765, 1414, 1848, 2000, 1848, 1414, 765,
                                  0, -765, -1414, -1848, -2000, -1848, -1414, -765};

    task automatic model_step(input int d, input logic v, input logic [11:0] rx,
                              input logic [11:0] rf, input logic ss);
        logic [32:0] e;
        longint      s;
        bit          b;
        if (ss) begin
            part_sum[d] = 0;
            part_cnt[d] = 0;
        end
        if (v) begin
            part_sum[d] += longint'($signed(rx)) * longint'($signed(rf));
            part_cnt[d]++;
            if (part_cnt[d] == sps_tab[d]) begin
                s = part_sum[d];
                b = (s >= 0);
                if (d == 0 && lb_mode && lfsr_q.size() > 0) b = lfsr_q.pop_front();
                e = {b, s[31:0]};
                if (d == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
                part_sum[d] = 0;
                part_cnt[d] = 0;
            end
        end
    endtask

    // driver: inputs change 1 time unit after the edge; the model is stepped
    // after the edge that accepts them.
    task automatic drive(input logic v, input logic [11:0] rx, input logic [11:0] rf,
                         input logic ss);
        bus4.sample_valid = v;
        bus4.rx_in        = rx;
        bus4.ref_in       = rf;
        bus4.sym_start    = ss;
        @(posedge clk);
        #1;
        model_step(0, v, rx, rf, ss);
        model_step(1, v, rx, rf, ss);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        bus4.sample_valid = 1'b0;
        bus4.rx_in        = '0;
        bus4.ref_in       = '0;
        bus4.sym_start    = 1'b0;
        part_sum = '{0, 0};
        part_cnt = '{0, 0};
        exp_q0.delete();
        exp_q1.delete();
        lfsr_q.delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic lb_symbol(input bit first, input int nsamp);
        bit b;
        int sn;
        int rx;
        b = lfsr[0];
        lfsr_q.push_back(b);
        for (int k = 0; k < nsamp; k++) begin
            sn = sine_tab[ph % 16];
            ph++;
            rx = b ? sn : -sn;
            drive(1'b1, 12'(rx), 12'(sn), first && (k == 0));
        end
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    endtask

    task automatic loopback(input int nsym);
        lb_mode = 1'b1;
        for (int s = 0; s < nsym; s++) lb_symbol(s == 0, 4);
        lb_mode = 1'b0;
    endtask

    // scoreboard / monitor
    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            check("rst_bv4",   bus4.bit_valid,   0);
            check("rst_bit4",  bus4.bit_out,     0);
            check("rst_corr4", bus4.corr_out,    0);
            check("rst_cnt4",  bus4.sample_cnt,  0);
            check("rst_bv16",  bus16.bit_valid,  0);
            check("rst_corr16", bus16.corr_out,  0);
            check("rst_cnt16", bus16.sample_cnt, 0);
        end else begin
            check("cnt4",  bus4.sample_cnt,  part_cnt[0]);
            check("cnt16", bus16.sample_cnt, part_cnt[1]);
            if (bus4.bit_valid) begin
                if (exp_q0.size() == 0) begin
                    check("unexpected_bv4", 1, 0);
                end else begin
                    e = exp_q0.pop_front();
                    check("corr4", bus4.corr_out, e[31:0]);
                    check("bit4",  bus4.bit_out,  e[32]);
                end
            end
            if (bus16.bit_valid) begin
                if (exp_q1.size() == 0) begin
                    check("unexpected_bv16", 1, 0);
                end else begin
                    e = exp_q1.pop_front();
                    check("corr16", bus16.corr_out, e[31:0]);
                    check("bit16",  bus16.bit_out,  e[32]);
                end
            end
        end
        if (final_chk && !final_done) begin
            check("left_q4",  exp_q0.size(), 0);
            check("left_q16", exp_q1.size(), 0);
            final_done = 1'b1;
        end
    end

    // stimulus
    initial begin
        total = 0;
        bad = 0;
        final_chk = 1'b0;
        final_done = 1'b0;
        lb_mode = 1'b0;
        lfsr = 8'hA5;
        ph = 0;
        apply_reset(3);
        repeat (2) drive(1'b0, 12'h0, 12'h0, 1'b0);

        // +100 * +100, one 4-sample symbol
        for (int i = 0; i < 4; i++) drive(1'b1, 12'd100, 12'd100, i == 0);
        // -100 * +100, then all-zero symbol (tie decides 1)
        for (int i = 0; i < 4; i++) drive(1'b1, 12'hF9C, 12'd100, i == 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 12'h000, 12'd100, 1'b0);
        repeat (3) drive(1'b0, 12'h0, 12'h0, 1'b0);

        // full-scale negative squared, 16 samples
        for (int i = 0; i < 16; i++) drive(1'b1, 12'h800, 12'h800, i == 0);
        repeat (3) drive(1'b0, 12'h0, 12'h0, 1'b0);

        // partial symbol abandoned by sym_start
        for (int i = 0; i < 2; i++) drive(1'b1, 12'd100, 12'd100, i == 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 12'd100, 12'hF9C, i == 0);
        repeat (3) drive(1'b0, 12'h0, 12'h0, 1'b0);

        // gapped samples
        for (int i = 0; i < 8; i++) drive(i % 2 == 0, 12'd50, 12'd50, i == 0);
        repeat (3) drive(1'b0, 12'h0, 12'h0, 1'b0);

        // sym_start on the cycle after a last sample: symbol still completes
        for (int i = 0; i < 4; i++) drive(1'b1, 12'd7, 12'd9, i == 0);
        drive(1'b1, 12'd3, 12'hFFD, 1'b1);
        repeat (3) drive(1'b0, 12'h0, 12'h0, 1'b0);

        // randomized stream with gaps and occasional realignment
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 12'($urandom_range(0, 4095)),
                  12'($urandom_range(0, 4095)), $urandom_range(0, 24) == 0);
        end
        repeat (3) drive(1'b0, 12'h0, 12'h0, 1'b0);

        // LFSR-keyed loopback, back-to-back symbols
        loopback(40);
        // reset mid-symbol, then resume
        lb_mode = 1'b1;
        lb_symbol(1'b1, 2);
        lb_mode = 1'b0;
        apply_reset(2);
        loopback(8);

        repeat (6) drive(1'b0, 12'h0, 12'h0, 1'b0);
        final_chk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
